// File: rtl/time_set_ctrl.sv
// Set-mode controller: debounced buttons drive RUN/SET_TIME/SET_DATE,
// field select, inc/dec pulses with auto-repeat, idle timeout and blink.
// Ports: clk; reset (sync, active-high); btn_mode/next/up/down raw inputs;
// mode[1:0]; select[5:0] one-hot field; button_inc/dec pulses; blink.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT_CYC  = 10000,
  parameter int BLINK_CYC    = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic [5:0] select,
  output logic       button_inc,
  output logic       button_dec,
  output logic       blink
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_W = $clog2(RMAX + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RAT_LAST = RP_W'(REPEAT_RATE - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_TIME = 2'b01,
    SET_DATE = 2'b10
  } mode_t;

  // bit order: 0 mode, 1 next, 2 up, 3 down
  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      lvl;
  logic [3:0]      lvl_q;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  mode_t           state_q;
  mode_t           state_d;
  logic [5:0]      sel_d;
  logic            inc_d;
  logic            dec_d;
  logic            rpt_ok;
  logic            rpt_ok_d;
  logic            rpt_ph;
  logic            rpt_ph_d;
  logic [RP_W-1:0] rpt_cnt;
  logic [RP_W-1:0] rpt_cnt_d;
  logic [TO_W-1:0] idle_cnt;
  logic [TO_W-1:0] idle_d;
  logic [BL_W-1:0] bl_cnt;
  logic [BL_W-1:0] bl_cnt_d;
  logic            blink_d;
  logic            in_set;
  logic            chg;
  logic            timeout;
  logic            up_only;
  logic            dn_only;

  assign raw = {btn_down, btn_up, btn_next, btn_mode};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press   = lvl & ~lvl_q;
  assign in_set  = (state_q != RUN);
  assign up_only = lvl[2] & ~lvl[3];
  assign dn_only = lvl[3] & ~lvl[2];
  assign timeout = in_set & ~(|press) & (idle_cnt == TO_LAST);

  always_comb begin
    state_d   = state_q;
    sel_d     = select;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    rpt_ok_d  = rpt_ok;
    rpt_ph_d  = rpt_ph;
    rpt_cnt_d = rpt_cnt;
    idle_d    = idle_cnt;
    blink_d   = blink;
    bl_cnt_d  = bl_cnt;
    chg       = 1'b0;

    if (press[0]) begin
      chg = 1'b1;
      unique case (state_q)
        RUN: begin
          state_d = SET_TIME;
          sel_d   = 6'b000100;
        end
        SET_TIME: begin
          state_d = SET_DATE;
          sel_d   = 6'b001000;
        end
        default: begin
          state_d = RUN;
          sel_d   = 6'b000000;
        end
      endcase
    end else if (press[1] && in_set) begin
      chg = 1'b1;
      if (state_q == SET_TIME) begin
        unique case (1'b1)
          select[2]: sel_d = 6'b000010;
          select[1]: sel_d = 6'b000001;
          default:   sel_d = 6'b000100;
        endcase
      end else begin
        unique case (1'b1)
          select[3]: sel_d = 6'b010000;
          select[4]: sel_d = 6'b100000;
          default:   sel_d = 6'b001000;
        endcase
      end
    end else if (timeout) begin
      chg     = 1'b1;
      state_d = RUN;
      sel_d   = 6'b000000;
    end

    // Repeat is armed by a press and disarmed by any mode/select change;
    // its counter only runs while exactly one of up/down is held.
    if (chg) begin
      rpt_ok_d  = 1'b0;
      rpt_ph_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (in_set) begin
      if ((press[2] && up_only) || (press[3] && dn_only)) begin
        inc_d     = press[2];
        dec_d     = press[3];
        rpt_ok_d  = 1'b1;
        rpt_ph_d  = 1'b0;
        rpt_cnt_d = '0;
      end else if (rpt_ok && (up_only || dn_only)) begin
        if (rpt_cnt == (rpt_ph ? RAT_LAST : DLY_LAST)) begin
          inc_d     = up_only;
          dec_d     = dn_only;
          rpt_ph_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt + 1'b1;
        end
      end else begin
        rpt_ph_d  = 1'b0;
        rpt_cnt_d = '0;
        if (press[2] || press[3]) rpt_ok_d = 1'b1;
      end
    end

    if ((|press) || (state_d == RUN)) begin
      idle_d = '0;
    end else if (idle_cnt != TO_LAST) begin
      idle_d = idle_cnt + 1'b1;
    end

    if (state_d == RUN) begin
      blink_d  = 1'b0;
      bl_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d  = 1'b1;
      bl_cnt_d = '0;
    end else if (bl_cnt == BL_LAST) begin
      blink_d  = ~blink;
      bl_cnt_d = '0;
    end else begin
      bl_cnt_d = bl_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      select     <= '0;
      button_inc <= 1'b0;
      button_dec <= 1'b0;
      rpt_ok     <= 1'b0;
      rpt_ph     <= 1'b0;
      rpt_cnt    <= '0;
      idle_cnt   <= '0;
      blink      <= 1'b0;
      bl_cnt     <= '0;
    end else begin
      state_q    <= state_d;
      select     <= sel_d;
      button_inc <= inc_d;
      button_dec <= dec_d;
      rpt_ok     <= rpt_ok_d;
      rpt_ph     <= rpt_ph_d;
      rpt_cnt    <= rpt_cnt_d;
      idle_cnt   <= idle_d;
      blink      <= blink_d;
      bl_cnt     <= bl_cnt_d;
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a predictive model queues expected
// pulses and mode/select changes; a negedge monitor pops and compares.
module tb_time_set_ctrl;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int TO = 200;
  localparam int BC = 8;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] mode;
  logic [5:0] select;
  logic       button_inc;
  logic       button_dec;
  logic       blink;

  time_set_ctrl #(
    .DEBOUNCE_CYC(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .TIMEOUT_CYC (TO),
    .BLINK_CYC   (BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .mode      (mode),
    .select    (select),
    .button_inc(button_inc),
    .button_dec(button_dec),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [1:0] mode;
    logic [5:0] sel;
  } st_ev_t;

  typedef struct {
    int edge_n;
    bit inc;
  } pl_ev_t;

  st_ev_t st_q[$];
  pl_ev_t pl_q[$];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pulse = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_st = 8'h00;

  // reference model state: mode 0/1/2, field position, last press edge
  int m_mode = 0;
  int m_pos = 0;
  int m_reload = 0;
  int tseq[3] = '{2, 1, 0};
  int dseq[3] = '{3, 4, 5};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] m_sel();
    logic [5:0] s;
    s = '0;
    if (m_mode == 1) s[tseq[m_pos]] = 1'b1;
    else if (m_mode == 2) s[dseq[m_pos]] = 1'b1;
    return s;
  endfunction

  task automatic push_state(input int e);
    st_ev_t x;
    x.edge_n = e;
    x.mode = 2'(m_mode);
    x.sel = m_sel();
    st_q.push_back(x);
  endtask

  task automatic push_pulse(input int e, input bit inc);
    pl_ev_t x;
    x.edge_n = e;
    x.inc = inc;
    pl_q.push_back(x);
  endtask

  // idle timeout that lands strictly before edge e
  task automatic expire(input int e);
    if (m_mode != 0 && m_reload + TO < e) begin
      m_mode = 0;
      m_pos = 0;
      push_state(m_reload + TO);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_mode != 0 && cyc + 1 == m_reload + TO) begin
      m_mode = 0;
      m_pos = 0;
      push_state(cyc + 1);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) tick();
  endtask

  // Drive btns for h cycles. A press appears D+2 edges after the first
  // sampling edge; the debounced level stays high D+1 edges past release.
  task automatic act(input logic [3:0] btns, input int h, input int gap);
    int t0;
    int p;
    int last_hi;
    t0 = cyc + 1;
    p = t0 + D + 2;
    last_hi = t0 + h + D + 1;
    if (h >= D) begin
      expire(p);
      if (btns[0]) begin
        m_mode = (m_mode + 1) % 3;
        m_pos = 0;
        push_state(p);
      end else if (btns[1] && m_mode != 0) begin
        m_pos = (m_pos + 1) % 3;
        push_state(p);
      end else if (m_mode != 0 &&
                   (btns[3:2] == 2'b01 || btns[3:2] == 2'b10)) begin
        for (int e = p; e <= last_hi && e < p + TO;
             e = (e == p) ? p + RD : e + RR)
          push_pulse(e, btns[2]);
      end
      m_reload = p;
    end
    {btn_down, btn_up, btn_next, btn_mode} = btns;
    repeat (h) tick();
    {btn_down, btn_up, btn_next, btn_mode} = 4'b0000;
    repeat (D + 3 + gap) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (pl_q.size() > 0 && pl_q[0].edge_n < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse: expected inc=%0b at edge %0d, not observed",
                 pl_q[0].inc, pl_q[0].edge_n);
        pl_q.delete(0);
      end
      while (st_q.size() > 0 && st_q[0].edge_n < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_state: expected mode=%0d sel=%b at edge %0d, not observed",
                 st_q[0].mode, st_q[0].sel, st_q[0].edge_n);
        st_q.delete(0);
      end
      if (button_inc || button_dec) begin
        n_pulse++;
        check("pulse_excl", int'(button_inc & button_dec), 0);
        if (pl_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: inc=%0b dec=%0b at edge %0d, none expected",
                   button_inc, button_dec, cyc);
        end else begin
          check("pulse_edge", cyc, pl_q[0].edge_n);
          check("pulse_inc", int'(button_inc), int'(pl_q[0].inc));
          pl_q.delete(0);
        end
      end
      if ({mode, select} != prev_st) begin
        if (st_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_state: mode=%0d sel=%b at edge %0d, none expected",
                   mode, select, cyc);
        end else begin
          check("state_edge", cyc, st_q[0].edge_n);
          check("state_mode", int'(mode), int'(st_q[0].mode));
          check("state_sel", int'(select), int'(st_q[0].sel));
          st_q.delete(0);
        end
        prev_st = {mode, select};
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mode"}, int'(mode), 0);
    check({tag, "_sel"}, int'(select), 0);
    check({tag, "_inc"}, int'(button_inc), 0);
    check({tag, "_dec"}, int'(button_dec), 0);
    check({tag, "_blink"}, int'(blink), 0);
  endtask

  initial begin
    int p;
    int tt;
    int base;
    int k;
    int t0;
    int rs;
    logic [3:0] b;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");
    mon_en = 1'b1;

    act(4'b0001, D + 2, 2);
    check("m1_mode", int'(mode), 1);
    check("m1_sel", int'(select), 6'b000100);
    act(4'b0001, D + 2, 2);
    check("m2_mode", int'(mode), 2);
    check("m2_sel", int'(select), 6'b001000);
    act(4'b0001, D + 2, 2);
    check("m3_mode", int'(mode), 0);
    check("m3_sel", int'(select), 0);

    act(4'b0001, D, 0);
    p = m_reload;
    wait_edge(p + 7);
    check("blink_p7", int'(blink), 1);
    wait_edge(p + 8);
    check("blink_p8", int'(blink), 0);
    wait_edge(p + 15);
    check("blink_p15", int'(blink), 0);
    wait_edge(p + 16);
    check("blink_p16", int'(blink), 1);

    act(4'b0010, D + 1, 1);
    check("next1_sel", int'(select), 6'b000010);
    act(4'b0010, D + 1, 1);
    check("next2_sel", int'(select), 6'b000001);
    act(4'b0010, D + 1, 1);
    check("next3_sel", int'(select), 6'b000100);

    act(4'b0001, D + 1, 1);
    check("date_mode", int'(mode), 2);
    base = n_pulse;
    act(4'b0100, 45, 3);
    check("hold_pulses", n_pulse - base, 6);
    base = n_pulse;
    act(4'b0100, D - 1, 3);
    check("glitch_pulses", n_pulse - base, 0);

    act(4'b0001, D + 1, 1);
    act(4'b0001, D + 1, 1);
    tt = m_reload + TO;
    wait_edge(tt - 1);
    check("pre_to_mode", int'(mode), 1);
    check("pre_to_blink", int'(blink), ((TO - 1) / BC) % 2 == 0 ? 1 : 0);
    wait_edge(tt);
    check("to_mode", int'(mode), 0);
    check("to_sel", int'(select), 0);
    check("to_blink", int'(blink), 0);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: act(4'b0001, $urandom_range(D, 10), $urandom_range(0, 8));
        1: act(4'b0010, $urandom_range(D, 10), $urandom_range(0, 8));
        2: act(4'b0100, $urandom_range(D, 70), $urandom_range(0, 8));
        3: act(4'b1000, $urandom_range(D, 70), $urandom_range(0, 8));
        4: begin
          b = 4'(1 << $urandom_range(0, 3));
          act(b, $urandom_range(1, D - 1), $urandom_range(0, 8));
        end
        5: act(4'b1100, $urandom_range(D, 40), $urandom_range(0, 8));
        default: act(4'b0011, $urandom_range(D, 10), $urandom_range(0, 8));
      endcase
    end

    while (m_mode != 1) act(4'b0001, D, 2);
    t0 = cyc + 1;
    p = t0 + D + 2;
    rs = p + RD + RR + 2;
    expire(p);
    for (int e = p; e < rs; e = (e == p) ? p + RD : e + RR)
      push_pulse(e, 1'b0);
    m_reload = p;
    btn_down = 1'b1;
    wait_edge(rs - 1);
    reset = 1'b1;
    m_mode = 0;
    m_pos = 0;
    push_state(rs);
    wait_edge(rs);
    check_idle_outputs("midrst");
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check("post_rst_mode", int'(mode), 0);
    btn_down = 1'b0;
    repeat (D + 6) tick();

    check("pulse_q_empty", pl_q.size(), 0);
    check("state_q_empty", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
